// File: rtl/comp_divider.sv
// 32-bit unsigned restoring divider, one quotient bit per clock under a Run/Ready handshake.
// Optional DIV_ZERO_DETECT_EN: short-circuits a zero divisor straight to DONE and raises DivZero.
module comp_divider (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Run,
   input  logic [31:0] Dividend_in,
   input  logic [31:0] Divisor_in,
   output logic [31:0] Quotient_out,
   output logic [31:0] Remainder_out,
   output logic        Ready,
   output logic [31:0] ALU_result,
   output logic        DivZero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state;
   logic [32:0] p;
   logic [31:0] q;
   logic [31:0] d;
   logic [4:0]  cnt;
   logic [32:0] trial;
   logic [33:0] diff;
   logic        unused_p_msb;

   // P < D holds before every shift, so P[32] never feeds the next trial
   assign trial        = {p[31:0], q[31]};
   assign diff         = {1'b0, trial} - {2'b00, d};
   assign unused_p_msb = p[32];

`ifdef DIV_ZERO_DETECT_EN
   logic dz;
`endif

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         p     <= '0;
         q     <= '0;
         d     <= '0;
         cnt   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         dz    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (Run) begin
                  cnt <= '0;
                  d   <= Divisor_in;
`ifdef DIV_ZERO_DETECT_EN
                  if (Divisor_in == 32'd0) begin
                     p     <= {1'b0, Dividend_in};
                     q     <= '1;
                     dz    <= 1'b1;
                     state <= S_DONE;
                  end else
`endif
                  begin
                     p     <= '0;
                     q     <= Dividend_in;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!diff[33]) begin
                  p <= diff[32:0];
                  q <= {q[30:0], 1'b1};
               end else begin
                  p <= trial;
                  q <= {q[30:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= S_DONE;
            end
            S_DONE: begin
               if (!Run) begin
                  state <= S_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                  dz    <= 1'b0;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign Quotient_out  = q;
   assign Remainder_out = p[31:0];
   assign Ready         = (state == S_DONE);
   assign ALU_result    = (state == S_CALC) ? diff[31:0] : 32'd0;

`ifdef DIV_ZERO_DETECT_EN
   assign DivZero = dz;
`else
   assign DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_comp_divider.sv
// Bench for comp_divider: directed corner cases plus random operands against plain-arithmetic division.
module tb_comp_divider;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Run;
   logic [31:0] Dividend_in;
   logic [31:0] Divisor_in;
   logic [31:0] Quotient_out;
   logic [31:0] Remainder_out;
   logic        Ready;
   logic [31:0] ALU_result;
   logic        DivZero;

   int n_pass  = 0;
   int n_total = 0;

`ifdef DIV_ZERO_DETECT_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   comp_divider dut (
      .clk(clk),
      .Reset(Reset),
      .Run(Run),
      .Dividend_in(Dividend_in),
      .Divisor_in(Divisor_in),
      .Quotient_out(Quotient_out),
      .Remainder_out(Remainder_out),
      .Ready(Ready),
      .ALU_result(ALU_result),
      .DivZero(DivZero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Runs one division; latency counts clock edges from the load edge to Ready.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input int hold);
      logic [31:0] eq, er, alu_exp;
      int          lat, exp_lat;
      bit          dzexp;
      eq      = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      er      = (b == 32'd0) ? a : a % b;
      dzexp   = DZ_EN && (b == 32'd0);
      exp_lat = dzexp ? 1 : 33;
      alu_exp = (a >> 31) - b;
      @(negedge clk);
      Dividend_in = a;
      Divisor_in  = b;
      Run         = 1'b1;
      lat         = 0;
      while (!Ready && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1 && !dzexp) check("alu_first", ALU_result, alu_exp);
         if (scramble) begin
            Dividend_in = $urandom;
            Divisor_in  = $urandom;
         end
      end
      check("latency", lat, exp_lat);
      check("quotient", Quotient_out, eq);
      check("remainder", Remainder_out, er);
      check("divzero", {31'd0, DivZero}, {31'd0, dzexp});
      check("alu_done", ALU_result, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_ready", {31'd0, Ready}, 32'd1);
         check("hold_quot", Quotient_out, eq);
         check("hold_rem", Remainder_out, er);
      end
      Run = 1'b0;
      @(negedge clk);
      check("ready_fall", {31'd0, Ready}, 32'd0);
      check("divzero_clr", {31'd0, DivZero}, 32'd0);
      check("idle_quot", Quotient_out, eq);
      check("idle_rem", Remainder_out, er);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra, rb;
      Reset       = 1'b1;
      Run         = 1'b0;
      Dividend_in = 32'd0;
      Divisor_in  = 32'd0;
      #2 Reset = 1'b0;
      #1;
      check("rst_quot", Quotient_out, 32'd0);
      check("rst_rem", Remainder_out, 32'd0);
      check("rst_ready", {31'd0, Ready}, 32'd0);
      check("rst_alu", ALU_result, 32'd0);
      check("rst_dz", {31'd0, DivZero}, 32'd0);
      @(negedge clk);
      Reset = 1'b1;

      do_div(32'd100, 32'd7, 1'b0, 0);
      do_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);
      do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
      do_div(32'd5, 32'd9, 1'b0, 0);
      do_div(32'h80000000, 32'd3, 1'b0, 0);
      do_div(32'd1234, 32'd0, 1'b0, 0);
      do_div(32'd100, 32'd7, 1'b0, 10);
      do_div(32'hDEADBEEF, 32'h0001_2345, 1'b1, 0);

      // Reset in the middle of an iteration discards everything
      @(negedge clk);
      Dividend_in = 32'd100;
      Divisor_in  = 32'd7;
      Run         = 1'b1;
      repeat (10) @(negedge clk);
      Reset = 1'b0;
      #1;
      check("mid_rst_quot", Quotient_out, 32'd0);
      check("mid_rst_rem", Remainder_out, 32'd0);
      check("mid_rst_ready", {31'd0, Ready}, 32'd0);
      check("mid_rst_alu", ALU_result, 32'd0);
      check("mid_rst_dz", {31'd0, DivZero}, 32'd0);
      Run = 1'b0;
      @(negedge clk);
      Reset = 1'b1;
      do_div(32'd50, 32'd6, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         if (i % 3 == 0) ra = ra >> $urandom_range(0, 31);
         rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
         do_div(ra, rb, (i % 4 == 1), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/comp_divider.md
# comp_divider

Sequential 32-bit unsigned restoring divider, the inverse companion of the iterative multiplier in the arithmetic unit. It accepts a dividend and divisor under a Run/Ready handshake and iterates one quotient bit per clock. It returns a 32-bit quotient and a 32-bit remainder. It exposes the per-iteration subtractor output for observation and sits beside the multiplier behind the same benches.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-low reset (low = reset)
- Run  input  1  start request; sampled in IDLE, must be held until Ready rises
- Dividend_in  input  32  unsigned dividend, sampled only on the load edge
- Divisor_in  input  32  unsigned divisor, sampled only on the load edge
- Quotient_out  output  32  quotient register; valid while Ready=1
- Remainder_out  output  32  remainder register; valid while Ready=1
- Ready  output  1  registered; high exactly while in DONE
- ALU_result  output  32  low 32 bits of current trial subtraction in CALC, 0 otherwise
- DivZero  output  1  divide-by-zero flag (see Configuration); valid while Ready=1

## Operation
- Registers: P (33-bit partial remainder), Q (32-bit dividend/quotient shift register), D (32-bit divisor copy), cnt (5-bit), state.
- States: IDLE, CALC, DONE.
- IDLE + Run=1:
  - Load P=0, Q=Dividend_in, D=Divisor_in, cnt=0.
  - Go to CALC.
- CALC, each edge:
  - T = {P[31:0], Q[31]} (33 bits); S = T − {1'b0, D}, computed at 34 bits.
  - If T ≥ D: P=S[32:0], Q={Q[30:0],1}; else P=T, Q={Q[30:0],0}.
  - cnt increments; when cnt=31 on this edge, go to DONE.
- DONE:
  - Ready=1; Quotient_out=Q, Remainder_out=P[31:0].
  - Stays in DONE while Run=1; goes to IDLE on the first edge with Run=0.
- Outputs Quotient_out/Remainder_out track Q/P[31:0] continuously; they hold their values in IDLE until the next load.
- Run changes and operand changes during CALC are ignored.
- Restart requires Run to fall and then rise again; holding Run high never re-triggers.
- Reset asserted (low) at any time, including mid-CALC:
  - Immediately forces state=IDLE and clears P, Q, D and cnt.
  - All outputs go to 0.
  - No partial result survives.

## Timing
- Reset values: Quotient_out=0, Remainder_out=0, Ready=0, ALU_result=0, DivZero=0.
- Load edge k (IDLE, Run=1) is followed by iterations on edges k+1 … k+32. Ready rises after edge k+32; latency is 33 clocks from load.
- Ready falls after the first edge in DONE that samples Run=0; a new load is possible on the following edge.
- ALU_result is combinational from P, Q and D; it is meaningful only in CALC.
- Invariant at each CALC edge: P < D before shift. T therefore always fits 33 bits, and the final remainder is less than D.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A load with Divisor_in=0 skips CALC and enters DONE on the next edge (latency 1 clock).
  - Results: Quotient_out=32'hFFFFFFFF, Remainder_out=Dividend_in, DivZero=1.
  - DivZero clears on leaving DONE.
- DIV_ZERO_DETECT_EN undefined:
  - DivZero is tied 0.
  - Divisor 0 runs the full 33-clock iteration; the algorithm naturally yields Quotient_out=32'hFFFFFFFF and Remainder_out=Dividend_in.

## Test plan
- Dividend 100, Divisor 7, Run held → Ready rises exactly 33 clocks after load; Quotient_out=14, Remainder_out=2, DivZero=0.
- Extremes: FFFFFFFF/1 → Q=FFFFFFFF, R=0; FFFFFFFF/FFFFFFFF → Q=1, R=0; 5/9 → Q=0, R=5; 80000000/3 → Q=2AAAAAAA, R=2.
- Divisor 0, dividend 1234 → Q=FFFFFFFF, R=1234.
  - With DIV_ZERO_DETECT_EN: Ready after 1 clock, DivZero=1.
  - Without: Ready after 33 clocks, DivZero=0.
- Reset pulled low at iteration 10 of 100/7 → all outputs 0 immediately; after release, a new Run with 50/6 → Q=8, R=2.
- Run held high for 10 clocks after Ready → Ready stays 1, outputs stable, no restart; Run low → Ready 0 next edge.
- Change Dividend_in/Divisor_in during CALC → result still reflects the operands sampled on the load edge.
